// File: rtl/xocc_chan_hub.sv
// xocc_chan_hub: CPU <-> XOCC accelerator command/response buffer hub.
// CPU words are assembled into CMD_WORDS-wide commands and queued per channel.
// Accelerators return 32-bit responses into per-channel queues that the CPU pops.
module xocc_chan_hub #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CMD_WORDS = 3,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            i_pad_clk,
    input  logic                            i_pad_rst,
    input  logic                            cpu_wr_vld,
    input  logic [CHW-1:0]                  cpu_wr_ch,
    input  logic [31:0]                     cpu_wr_data,
    output logic                            cpu_wr_rdy,
    input  logic                            cpu_rsp_pop,
    input  logic [CHW-1:0]                  cpu_rsp_ch,
    output logic                            cpu_rsp_vld,
    output logic [31:0]                     cpu_rsp_data,
    output logic                            cpu_rsp_err,
    input  logic [NUM_CH-1:0]               cpu_ch_flush,
    input  logic [NUM_CH-1:0]               cpu_err_clr,
    output logic [NUM_CH-1:0]               ch_err,
    output logic [NUM_CH-1:0]               rsp_irq,
    output logic [NUM_CH*32*CMD_WORDS-1:0]  xocc_cmd_buffer,
    output logic [NUM_CH-1:0]               xocc_cmd_empty,
    input  logic [NUM_CH-1:0]               xocc_cmd_rd_en,
    input  logic [NUM_CH*32-1:0]            xocc_rsp_buffer,
    input  logic [NUM_CH-1:0]               xocc_rsp_wr_en,
    output logic [NUM_CH-1:0]               xocc_rsp_full
);

    localparam int unsigned CMD_W = 32 * CMD_WORDS;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned WCW   = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;

    localparam logic [WCW-1:0] WCNT_LAST = WCW'(CMD_WORDS - 1);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);

    logic [NUM_CH-1:0] cmd_full;
    logic [NUM_CH-1:0] rsp_empty;
    logic [NUM_CH-1:0] rsp_pop_v;
    logic [NUM_CH-1:0] pop_err_v;
    logic [31:0]       rsp_head [NUM_CH];
    logic              rsp_ch_ok;
    logic              pop_ok;
    logic              pop_bad;
    logic [31:0]       pop_data;

    assign rsp_ch_ok = 32'(cpu_rsp_ch) < NUM_CH;

    // Write ready follows the selected channel's full flag; unknown channels always accept
    always_comb begin
        cpu_wr_rdy = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cpu_wr_ch == CHW'(i) && cmd_full[i]) begin
                cpu_wr_rdy = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        logic [WCW-1:0]   wcnt;
        logic [CMD_W-1:0] asm_q;
        logic [CMD_W-1:0] cmd_in;
        logic [CMD_W-1:0] cmd_mem [DEPTH];
        logic [PW-1:0]    cmd_wp;
        logic [PW-1:0]    cmd_rp;
        logic [CW-1:0]    cmd_cnt;
        logic [31:0]      rsp_mem [DEPTH];
        logic [PW-1:0]    rsp_wp;
        logic [PW-1:0]    rsp_rp;
        logic [CW-1:0]    rsp_cnt;
        logic             err_q;
        logic             flush;
        logic             wr_acc;
        logic             cmd_push;
        logic             cmd_pop;
        logic             rd_err;
        logic             rsp_push;
        logic             rsp_drop;
        logic             pop_hit;
        logic             rsp_pop;
        logic             pop_err;

        assign flush = cpu_ch_flush[g];

        assign cmd_full[g]       = cmd_cnt == CNT_FULL;
        assign xocc_cmd_empty[g] = cmd_cnt == '0;
        assign xocc_rsp_full[g]  = rsp_cnt == CNT_FULL;
        assign rsp_empty[g]      = rsp_cnt == '0;
        assign rsp_irq[g]        = !rsp_empty[g];
        assign ch_err[g]         = err_q;

        assign xocc_cmd_buffer[g*CMD_W +: CMD_W] = cmd_mem[cmd_rp];
        assign rsp_head[g]                       = rsp_mem[rsp_rp];

        // All event qualifiers use the pre-cycle flags; flush suppresses every push/pop
        assign wr_acc   = cpu_wr_vld && (cpu_wr_ch == CHW'(g)) && !cmd_full[g];
        assign cmd_push = wr_acc && (wcnt == WCNT_LAST) && !flush;
        assign rd_err   = xocc_cmd_rd_en[g] && xocc_cmd_empty[g];
        assign cmd_pop  = xocc_cmd_rd_en[g] && !xocc_cmd_empty[g] && !flush;
        assign rsp_drop = xocc_rsp_wr_en[g] && xocc_rsp_full[g];
        assign rsp_push = xocc_rsp_wr_en[g] && !xocc_rsp_full[g] && !flush;
        assign pop_hit  = cpu_rsp_pop && (cpu_rsp_ch == CHW'(g));
        assign pop_err  = pop_hit && rsp_empty[g];
        assign rsp_pop  = pop_hit && !rsp_empty[g] && !flush;

        assign rsp_pop_v[g] = rsp_pop;
        assign pop_err_v[g] = pop_err;

        // Merge the incoming word into the partially assembled command
        always_comb begin
            cmd_in = asm_q;
            cmd_in[32*int'(wcnt) +: 32] = cpu_wr_data;
        end

        // Word counter and assembly register
        always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
            if (i_pad_rst) begin
                wcnt  <= '0;
                asm_q <= '0;
            end else if (flush) begin
                wcnt <= '0;
            end else if (wr_acc) begin
                asm_q <= cmd_in;
                wcnt  <= (wcnt == WCNT_LAST) ? '0 : wcnt + WCW'(1);
            end
        end

        // Command FIFO
        always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
            if (i_pad_rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    cmd_mem[i] <= '0;
                end
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                cmd_cnt <= '0;
            end else if (flush) begin
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                cmd_cnt <= '0;
            end else begin
                if (cmd_push) begin
                    cmd_mem[cmd_wp] <= cmd_in;
                    cmd_wp          <= cmd_wp + PW'(1);
                end
                if (cmd_pop) begin
                    cmd_rp <= cmd_rp + PW'(1);
                end
                case ({cmd_push, cmd_pop})
                    2'b10:   cmd_cnt <= cmd_cnt + CW'(1);
                    2'b01:   cmd_cnt <= cmd_cnt - CW'(1);
                    default: cmd_cnt <= cmd_cnt;
                endcase
            end
        end

        // Response FIFO
        always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
            if (i_pad_rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    rsp_mem[i] <= '0;
                end
                rsp_wp  <= '0;
                rsp_rp  <= '0;
                rsp_cnt <= '0;
            end else if (flush) begin
                rsp_wp  <= '0;
                rsp_rp  <= '0;
                rsp_cnt <= '0;
            end else begin
                if (rsp_push) begin
                    rsp_mem[rsp_wp] <= xocc_rsp_buffer[g*32 +: 32];
                    rsp_wp          <= rsp_wp + PW'(1);
                end
                if (rsp_pop) begin
                    rsp_rp <= rsp_rp + PW'(1);
                end
                case ({rsp_push, rsp_pop})
                    2'b10:   rsp_cnt <= rsp_cnt + CW'(1);
                    2'b01:   rsp_cnt <= rsp_cnt - CW'(1);
                    default: rsp_cnt <= rsp_cnt;
                endcase
            end
        end

        // Sticky error: a new error event beats a same-cycle clear
        always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
            if (i_pad_rst) begin
                err_q <= 1'b0;
            end else if (rd_err || rsp_drop || pop_err) begin
                err_q <= 1'b1;
            end else if (cpu_err_clr[g]) begin
                err_q <= 1'b0;
            end
        end
    end

    // Select the popped response head and classify the pop request
    always_comb begin
        pop_ok   = |rsp_pop_v;
        pop_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (rsp_pop_v[i]) begin
                pop_data = rsp_head[i];
            end
        end
        pop_bad = cpu_rsp_pop && (!rsp_ch_ok || (|pop_err_v));
    end

    // Registered CPU response port
    always_ff @(posedge i_pad_clk or posedge i_pad_rst) begin
        if (i_pad_rst) begin
            cpu_rsp_vld  <= 1'b0;
            cpu_rsp_data <= '0;
            cpu_rsp_err  <= 1'b0;
        end else begin
            cpu_rsp_vld <= pop_ok;
            cpu_rsp_err <= pop_bad;
            if (pop_ok) begin
                cpu_rsp_data <= pop_data;
            end
        end
    end

endmodule

// File: tb/tb_xocc_chan_hub.sv
// tb_xocc_chan_hub: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the hub.
module tb_xocc_chan_hub;

    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned CMD_WORDS = 3;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CMD_W     = 32 * CMD_WORDS;

    logic                      i_pad_clk;
    logic                      i_pad_rst;
    logic                      cpu_wr_vld;
    logic [CHW-1:0]            cpu_wr_ch;
    logic [31:0]               cpu_wr_data;
    logic                      cpu_wr_rdy;
    logic                      cpu_rsp_pop;
    logic [CHW-1:0]            cpu_rsp_ch;
    logic                      cpu_rsp_vld;
    logic [31:0]               cpu_rsp_data;
    logic                      cpu_rsp_err;
    logic [NUM_CH-1:0]         cpu_ch_flush;
    logic [NUM_CH-1:0]         cpu_err_clr;
    logic [NUM_CH-1:0]         ch_err;
    logic [NUM_CH-1:0]         rsp_irq;
    logic [NUM_CH*CMD_W-1:0]   xocc_cmd_buffer;
    logic [NUM_CH-1:0]         xocc_cmd_empty;
    logic [NUM_CH-1:0]         xocc_cmd_rd_en;
    logic [NUM_CH*32-1:0]      xocc_rsp_buffer;
    logic [NUM_CH-1:0]         xocc_rsp_wr_en;
    logic [NUM_CH-1:0]         xocc_rsp_full;

    xocc_chan_hub #(
        .NUM_CH    (NUM_CH),
        .CMD_WORDS (CMD_WORDS),
        .DEPTH     (DEPTH)
    ) dut (
        .i_pad_clk       (i_pad_clk),
        .i_pad_rst       (i_pad_rst),
        .cpu_wr_vld      (cpu_wr_vld),
        .cpu_wr_ch       (cpu_wr_ch),
        .cpu_wr_data     (cpu_wr_data),
        .cpu_wr_rdy      (cpu_wr_rdy),
        .cpu_rsp_pop     (cpu_rsp_pop),
        .cpu_rsp_ch      (cpu_rsp_ch),
        .cpu_rsp_vld     (cpu_rsp_vld),
        .cpu_rsp_data    (cpu_rsp_data),
        .cpu_rsp_err     (cpu_rsp_err),
        .cpu_ch_flush    (cpu_ch_flush),
        .cpu_err_clr     (cpu_err_clr),
        .ch_err          (ch_err),
        .rsp_irq         (rsp_irq),
        .xocc_cmd_buffer (xocc_cmd_buffer),
        .xocc_cmd_empty  (xocc_cmd_empty),
        .xocc_cmd_rd_en  (xocc_cmd_rd_en),
        .xocc_rsp_buffer (xocc_rsp_buffer),
        .xocc_rsp_wr_en  (xocc_rsp_wr_en),
        .xocc_rsp_full   (xocc_rsp_full)
    );

    initial i_pad_clk = 1'b0;
    always #5 i_pad_clk = ~i_pad_clk;

    typedef struct {
        logic                 wr_vld;
        logic [CHW-1:0]       wr_ch;
        logic [31:0]          wr_data;
        logic                 rsp_pop;
        logic [CHW-1:0]       rsp_ch;
        logic [NUM_CH-1:0]    flush;
        logic [NUM_CH-1:0]    err_clr;
        logic [NUM_CH-1:0]    rd_en;
        logic [NUM_CH-1:0]    rsp_wr_en;
        logic [NUM_CH*32-1:0] rsp_buf;
    } in_t;

    typedef struct {
        in_t               stim;
        logic [NUM_CH-1:0] exp_empty;
        logic [NUM_CH-1:0] exp_err;
        logic              chk_buf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-channel queues plus the partially assembled command
    logic [CMD_W-1:0]  cmd_q [NUM_CH][$];
    logic [31:0]       rsp_q [NUM_CH][$];
    int                wcnt_m [NUM_CH];
    logic [CMD_W-1:0]  asm_m [NUM_CH];
    logic [NUM_CH-1:0] err_m;
    logic              exp_vld;
    logic              exp_perr;
    logic [31:0]       exp_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t s;
        s.wr_vld    = 1'b0;
        s.wr_ch     = '0;
        s.wr_data   = '0;
        s.rsp_pop   = 1'b0;
        s.rsp_ch    = '0;
        s.flush     = '0;
        s.err_clr   = '0;
        s.rd_en     = '0;
        s.rsp_wr_en = '0;
        s.rsp_buf   = '0;
        return s;
    endfunction

    function automatic in_t wr(input int ch, input logic [31:0] d);
        in_t s;
        s         = idle();
        s.wr_vld  = 1'b1;
        s.wr_ch   = CHW'(ch);
        s.wr_data = d;
        return s;
    endfunction

    function automatic vec_t mk(input logic wv, input logic [CHW-1:0] wc, input logic [31:0] wd,
                                input logic [NUM_CH-1:0] rd, input logic [NUM_CH-1:0] clr,
                                input logic [NUM_CH-1:0] ee, input logic [NUM_CH-1:0] er,
                                input logic cb);
        vec_t v;
        v.stim         = idle();
        v.stim.wr_vld  = wv;
        v.stim.wr_ch   = wc;
        v.stim.wr_data = wd;
        v.stim.rd_en   = rd;
        v.stim.err_clr = clr;
        v.exp_empty    = ee;
        v.exp_err      = er;
        v.chk_buf      = cb;
        return v;
    endfunction

    task automatic drive(input in_t s);
        cpu_wr_vld      = s.wr_vld;
        cpu_wr_ch       = s.wr_ch;
        cpu_wr_data     = s.wr_data;
        cpu_rsp_pop     = s.rsp_pop;
        cpu_rsp_ch      = s.rsp_ch;
        cpu_ch_flush    = s.flush;
        cpu_err_clr     = s.err_clr;
        xocc_cmd_rd_en  = s.rd_en;
        xocc_rsp_wr_en  = s.rsp_wr_en;
        xocc_rsp_buffer = s.rsp_buf;
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cmd_q[c].delete();
            rsp_q[c].delete();
            wcnt_m[c] = 0;
            asm_m[c]  = '0;
        end
        err_m    = '0;
        exp_vld  = 1'b0;
        exp_perr = 1'b0;
        exp_data = '0;
    endtask

    function automatic logic model_rdy(input in_t s);
        if (int'(s.wr_ch) >= int'(NUM_CH)) return 1'b1;
        return cmd_q[int'(s.wr_ch)].size() != int'(DEPTH);
    endfunction

    // One clock edge of the hub, expressed as queue operations on the pre-edge state
    task automatic model_edge(input in_t s);
        logic [NUM_CH-1:0] cf, ce, rf, re, set;
        int rc;
        rc = int'(s.rsp_ch);
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cf[c] = cmd_q[c].size() == int'(DEPTH);
            ce[c] = cmd_q[c].size() == 0;
            rf[c] = rsp_q[c].size() == int'(DEPTH);
            re[c] = rsp_q[c].size() == 0;
        end
        set      = '0;
        exp_vld  = 1'b0;
        exp_perr = 1'b0;
        if (s.rsp_pop) begin
            if (rc >= int'(NUM_CH)) begin
                exp_perr = 1'b1;
            end else if (re[rc]) begin
                exp_perr = 1'b1;
                set[rc]  = 1'b1;
            end else if (!s.flush[rc]) begin
                exp_vld  = 1'b1;
                exp_data = rsp_q[rc][0];
            end
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (s.rd_en[c] && ce[c]) set[c] = 1'b1;
            if (s.rsp_wr_en[c] && rf[c]) set[c] = 1'b1;
            if (s.flush[c]) begin
                cmd_q[c].delete();
                rsp_q[c].delete();
                wcnt_m[c] = 0;
            end else begin
                if (s.rd_en[c] && !ce[c]) void'(cmd_q[c].pop_front());
                if (s.wr_vld && int'(s.wr_ch) == c && !cf[c]) begin
                    asm_m[c][32*wcnt_m[c] +: 32] = s.wr_data;
                    if (wcnt_m[c] == int'(CMD_WORDS) - 1) begin
                        cmd_q[c].push_back(asm_m[c]);
                        wcnt_m[c] = 0;
                    end else begin
                        wcnt_m[c]++;
                    end
                end
                if (s.rsp_wr_en[c] && !rf[c]) rsp_q[c].push_back(s.rsp_buf[32*c +: 32]);
                if (exp_vld && rc == c) void'(rsp_q[c].pop_front());
            end
            if (set[c]) err_m[c] = 1'b1;
            else if (s.err_clr[c]) err_m[c] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            chk($sformatf("cmd_empty[%0d]", c), xocc_cmd_empty[c], cmd_q[c].size() == 0);
            chk($sformatf("rsp_full[%0d]", c), xocc_rsp_full[c], rsp_q[c].size() == int'(DEPTH));
            chk($sformatf("rsp_irq[%0d]", c), rsp_irq[c], rsp_q[c].size() != 0);
            chk($sformatf("ch_err[%0d]", c), ch_err[c], err_m[c]);
            if (cmd_q[c].size() != 0)
                chk($sformatf("cmd_head[%0d]", c), xocc_cmd_buffer[c*CMD_W +: CMD_W], cmd_q[c][0]);
        end
        chk("rsp_vld", cpu_rsp_vld, exp_vld);
        chk("rsp_err", cpu_rsp_err, exp_perr);
        if (exp_vld) chk("rsp_data", cpu_rsp_data, exp_data);
    endtask

    // Drive one cycle: check ready before the edge, then all registered outputs after it
    task automatic step(input in_t s);
        drive(s);
        #1;
        chk("wr_rdy", cpu_wr_rdy, model_rdy(s));
        @(posedge i_pad_clk);
        model_edge(s);
        #1;
        check_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_empty"}, xocc_cmd_empty, {NUM_CH{1'b1}});
        chk({tag, "_rsp_full"}, xocc_rsp_full, '0);
        chk({tag, "_cmd_buffer"}, xocc_cmd_buffer, '0);
        chk({tag, "_rsp_vld"}, cpu_rsp_vld, 1'b0);
        chk({tag, "_rsp_data"}, cpu_rsp_data, '0);
        chk({tag, "_rsp_err"}, cpu_rsp_err, 1'b0);
        chk({tag, "_ch_err"}, ch_err, '0);
        chk({tag, "_rsp_irq"}, rsp_irq, '0);
        chk({tag, "_wr_rdy"}, cpu_wr_rdy, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [9];
        in_t  s;
        logic [CMD_W-1:0] cmd1;
        cmd1 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};

        tbl[0] = mk(1'b1, CHW'(1), 32'h11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
        tbl[1] = mk(1'b1, CHW'(1), 32'h22, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
        tbl[2] = mk(1'b1, CHW'(1), 32'h33, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1);
        tbl[3] = mk(1'b0, CHW'(0), 32'h0,  2'b00, 2'b00, 2'b01, 2'b00, 1'b1);
        tbl[4] = mk(1'b0, CHW'(0), 32'h0,  2'b01, 2'b01, 2'b01, 2'b01, 1'b1);
        tbl[5] = mk(1'b0, CHW'(0), 32'h0,  2'b00, 2'b01, 2'b01, 2'b00, 1'b1);
        tbl[6] = mk(1'b0, CHW'(0), 32'h0,  2'b10, 2'b00, 2'b11, 2'b00, 1'b0);
        tbl[7] = mk(1'b0, CHW'(0), 32'h0,  2'b10, 2'b00, 2'b11, 2'b10, 1'b0);
        tbl[8] = mk(1'b0, CHW'(0), 32'h0,  2'b00, 2'b10, 2'b11, 2'b00, 1'b0);

        // Reset
        i_pad_rst = 1'b1;
        drive(idle());
        model_reset();
        repeat (2) @(posedge i_pad_clk);
        #1;
        chk_reset_vals("rst");
        @(negedge i_pad_clk);
        i_pad_rst = 1'b0;
        @(posedge i_pad_clk);
        #1;
        chk_reset_vals("post_rst");

        // Command assembly and sticky error vectors
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].stim);
            chk($sformatf("tbl%0d_empty", i), xocc_cmd_empty, tbl[i].exp_empty);
            chk($sformatf("tbl%0d_err", i), ch_err, tbl[i].exp_err);
            if (tbl[i].chk_buf) chk($sformatf("tbl%0d_buf1", i), xocc_cmd_buffer[CMD_W +: CMD_W], cmd1);
        end

        // Command FIFO full and back-pressure on ch0
        for (int k = 0; k < 12; k++) step(wr(0, 32'h100 + 32'(k)));
        chk("bp_empty0", xocc_cmd_empty[0], 1'b0);
        s = wr(0, 32'hAAA);
        step(s);
        chk("bp_rdy_full", cpu_wr_rdy, 1'b0);
        s.rd_en = 2'b01;
        step(s);
        chk("bp_rdy_after_pop", cpu_wr_rdy, 1'b1);
        chk("bp_head_order", xocc_cmd_buffer[0 +: CMD_W], {32'h105, 32'h104, 32'h103});
        s.rd_en = 2'b00;
        step(s);
        step(wr(0, 32'hBBB));
        step(wr(0, 32'hCCC));
        s = idle();
        s.rd_en = 2'b01;
        repeat (3) step(s);
        chk("bp_tail_cmd", xocc_cmd_buffer[0 +: CMD_W], {32'hCCC, 32'hBBB, 32'hAAA});
        step(s);
        chk("bp_drained", xocc_cmd_empty[0], 1'b1);

        // Response overflow and underflow on ch0
        for (int k = 0; k < 5; k++) begin
            s = idle();
            s.rsp_wr_en = 2'b01;
            s.rsp_buf[31:0] = 32'hD0 + 32'(k);
            step(s);
            if (k == 0) chk("ov_irq", rsp_irq[0], 1'b1);
            if (k == 3) chk("ov_full", xocc_rsp_full[0], 1'b1);
            if (k == 3) chk("ov_err_before", ch_err[0], 1'b0);
        end
        chk("ov_err", ch_err[0], 1'b1);
        for (int k = 0; k < 5; k++) begin
            s = idle();
            s.rsp_pop = 1'b1;
            s.rsp_ch  = CHW'(0);
            step(s);
            if (k < 4) begin
                chk($sformatf("un_vld%0d", k), cpu_rsp_vld, 1'b1);
                chk($sformatf("un_data%0d", k), cpu_rsp_data, 32'hD0 + 32'(k));
            end else begin
                chk("un_err", cpu_rsp_err, 1'b1);
                chk("un_vld_low", cpu_rsp_vld, 1'b0);
                chk("un_irq", rsp_irq[0], 1'b0);
            end
        end
        s = idle();
        s.err_clr = 2'b01;
        step(s);
        chk("ov_err_clr", ch_err[0], 1'b0);

        // Flush of ch1 with a queued command and a partial one
        for (int k = 1; k <= 5; k++) step(wr(1, 32'h200 + 32'(k)));
        chk("fl_pre_empty", xocc_cmd_empty[1], 1'b0);
        s = wr(1, 32'hBAD);
        s.flush = 2'b10;
        step(s);
        chk("fl_empty", xocc_cmd_empty[1], 1'b1);
        for (int k = 1; k <= 3; k++) step(wr(1, 32'h300 + 32'(k)));
        chk("fl_clean_empty", xocc_cmd_empty[1], 1'b0);
        chk("fl_clean_cmd", xocc_cmd_buffer[CMD_W +: CMD_W], {32'h303, 32'h302, 32'h301});
        s = idle();
        s.rd_en = 2'b10;
        step(s);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit fill;
            fill = ((i / 100) % 2) == 0;
            s = idle();
            s.wr_vld  = $urandom_range(0, 1) == 1;
            s.wr_ch   = CHW'($urandom_range(0, (1 << CHW) - 1));
            s.wr_data = $urandom;
            s.rsp_pop = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            s.rsp_ch  = CHW'($urandom_range(0, (1 << CHW) - 1));
            for (int c = 0; c < int'(NUM_CH); c++) begin
                s.flush[c]     = $urandom_range(0, 31) == 0;
                s.err_clr[c]   = $urandom_range(0, 7) == 0;
                s.rd_en[c]     = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
                s.rsp_wr_en[c] = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
                s.rsp_buf[32*c +: 32] = $urandom;
            end
            if (s.rsp_pop && int'(s.rsp_ch) < int'(NUM_CH) && s.flush[int'(s.rsp_ch)]) s.rsp_pop = 1'b0;
            step(s);
        end

        // Asynchronous reset in the middle of command assembly
        s = idle();
        s.flush = '1;
        step(s);
        for (int k = 1; k <= 4; k++) step(wr(0, 32'h400 + 32'(k)));
        s = idle();
        s.rsp_wr_en = 2'b11;
        s.rsp_buf   = {32'hE1, 32'hE0};
        s.rd_en     = 2'b10;
        step(s);
        s = idle();
        s.rsp_pop = 1'b1;
        s.rsp_ch  = CHW'(0);
        step(s);
        chk("ar_pre_vld", cpu_rsp_vld, 1'b1);
        chk("ar_pre_err", ch_err[1], 1'b1);
        drive(idle());
        #2;
        i_pad_rst = 1'b1;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(negedge i_pad_clk);
        i_pad_rst = 1'b0;
        @(posedge i_pad_clk);
        #1;
        for (int k = 1; k <= 3; k++) step(wr(0, 32'h500 + 32'(k)));
        chk("ar_clean_cmd", xocc_cmd_buffer[0 +: CMD_W], {32'h503, 32'h502, 32'h501});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
